// File: rtl/mux_sel_rr_arbiter_v.sv
// Round-robin arbiter feeding the 4:1 8-bit code mux.
// Drives the mux select code and enable for one source at a time.
// After each grant it inserts one GAP cycle with the enable low.
// Optional hold-time limit: define HOLD_TIMEOUT_EN to revoke a grant after
// HOLD_MAX enable cycles and pulse o_timeout. Without the macro the grant is
// held until i_done or until the grantee withdraws, and o_timeout is tied to 0.
module mux_sel_rr_arbiter_v #(
    parameter int unsigned HOLD_MAX = 8,
    parameter int unsigned CNT_W    = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_req,
    input  logic       i_done,
    output logic [1:0] o_sel_code,
    output logic       o_en,
    output logic [3:0] o_grant,
    output logic       o_busy,
    output logic       o_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GRANT = 2'b01,
        ST_GAP   = 2'b10
    } state_t;

    // Reject illegal parameter values at elaboration.
    if (HOLD_MAX < 1 || HOLD_MAX > 255 || HOLD_MAX > (2 ** CNT_W) - 1) begin : g_bad_hold_max
        $error("mux_sel_rr_arbiter_v: HOLD_MAX must be 1..255 and fit in CNT_W bits");
    end

    state_t     state_q;
    logic [1:0] last_q;
    logic [1:0] sel_q;
    logic       en_q;
    logic [3:0] grant_q;
    logic       busy_q;

    logic [1:0] pick_d;
    logic       pick_vld;
    logic [1:0] idx;
    logic       release_req;
    logic       hold_hit;

    // Round-robin search: first requester at or after last+1, wrapping.
    always_comb begin
        pick_d   = '0;
        pick_vld = 1'b0;
        idx      = '0;
        for (int unsigned i = 1; i <= 4; i++) begin
            idx = last_q + 2'(i);
            if (!pick_vld && i_req[idx]) begin
                pick_d   = idx;
                pick_vld = 1'b1;
            end
        end
    end

    // Grantee finished or withdrew its request.
    assign release_req = i_done || !i_req[sel_q];

`ifdef HOLD_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q;
    logic             tout_q;

    assign hold_hit = (cnt_q == CNT_W'(HOLD_MAX - 1));

    // Hold counter: cleared while idle, counts GRANT cycles, saturates at HOLD_MAX.
    // The timeout pulse is raised only when done/withdraw did not end the grant.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q  <= '0;
            tout_q <= 1'b0;
        end else begin
            tout_q <= (state_q == ST_GRANT) && !release_req && hold_hit;
            if (state_q != ST_GRANT) begin
                cnt_q <= '0;
            end else if (cnt_q != CNT_W'(HOLD_MAX)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign o_timeout = tout_q;
`else
    assign hold_hit  = 1'b0;
    assign o_timeout = 1'b0;
`endif

    // Arbiter FSM with registered mux controls.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            last_q  <= 2'b11;
            sel_q   <= '0;
            en_q    <= 1'b0;
            grant_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_vld) begin
                        state_q <= ST_GRANT;
                        sel_q   <= pick_d;
                        en_q    <= 1'b1;
                        grant_q <= 4'b0001 << pick_d;
                        busy_q  <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    if (release_req || hold_hit) begin
                        state_q <= ST_GAP;
                        last_q  <= sel_q;
                        en_q    <= 1'b0;
                        grant_q <= '0;
                    end
                end
                ST_GAP: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    sel_q   <= '0;
                    en_q    <= 1'b0;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_sel_code = sel_q;
    assign o_en       = en_q;
    assign o_grant    = grant_q;
    assign o_busy     = busy_q;

endmodule
